ethernet_receiver: RTL and testbench
====================================

# ethernet_receiver

Receive-side counterpart of the modem transmit path. It samples one 4-bit nibble from the modem every four CLK cycles and hunts for a preamble/start delimiter. It then assembles a 16-bit length word and 16-bit payload words, MSB nibble first, and writes the payload words into packet memory starting at a fixed base position. It sits between the modem's nibble output and the packet memory write port, and reports frame completion or abort to the control logic.

## Interface
- START_WR_POS, 15'd256, first memory word address used after reset; also the wrap target of the write pointer
- MAX_WORDS, 1024, largest accepted payload length in 16-bit words
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- fromModem  input  4  received nibble, valid on sample slots
- modemValid  input  1  carrier present; sampled on sample slots
- toMemory  output  16  write data
- writeMemLoc  output  15  write address
- memWe  output  1  one-cycle write strobe
- frameLen  output  16  length field of the current/last accepted frame
- frameDone  output  1  one-cycle pulse, frame fully written
- frameErr  output  1  one-cycle pulse, frame rejected or aborted

## Operation
- Free-running 2-bit phase counter. Sample slot = rising edge with phase==2'b00. All state changes happen only on sample slots.
- The write pointer wrPtr starts at START_WR_POS and persists across frames. It increments after each write. After 15'h7FFF it wraps to START_WR_POS, not 0.
- States: HUNT, LEN, DATA.
- HUNT:
  - nibble 4'h5 increments the preamble count, saturating at 2.
  - 4'hD with count==2 clears the nibble/word accumulators, latches frameStart=wrPtr, and goes to LEN.
  - Any other nibble, or 4'hD with count<2, clears the count.
  - modemValid low clears the count.
- LEN: shift in 4 nibbles MSB first. On the 4th nibble, latch frameLen and apply:
  - len==0: pulse frameDone, go to HUNT, no writes.
  - len>MAX_WORDS: pulse frameErr, go to HUNT, frameLen still updated.
  - Otherwise: remaining=len, go to DATA.
- DATA: shift in 4 nibbles per word. On the 4th nibble:
  - drive toMemory=word, writeMemLoc=wrPtr, memWe=1.
  - advance wrPtr and decrement remaining.
  - If remaining becomes 0, pulse frameDone and go to HUNT.
- Abort: modemValid==0 on a sample slot in LEN or DATA triggers frameErr, wrPtr restored to frameStart, partial nibbles discarded, and return to HUNT. Words already written stay in memory but will be overwritten by the next frame.
- modemValid is ignored on non-slot cycles.
- Preamble count is cleared on entry to HUNT.

## Timing
- Reset values:
  - phase=0, state=HUNT, wrPtr=START_WR_POS
  - toMemory=0, writeMemLoc=START_WR_POS, memWe=0
  - frameLen=0, frameDone=0, frameErr=0
- First sample slot is the first rising edge after RST_N deasserts.
- All outputs are registered. A 4th-nibble sample at edge k makes memWe/toMemory/writeMemLoc valid in the cycle after edge k. memWe drops at edge k+1.
- frameDone is asserted in the same cycle as the final memWe.
- frameErr is asserted in the cycle after the offending slot.
- Throughput: at most one write per 16 CLK.
- toMemory and writeMemLoc hold their value between writes.
- Reset asserted mid-frame clears everything immediately. Memory contents are not touched.
- Simultaneous events: 4th nibble of the last word together with modemValid low counts as an abort. No write occurs, and frameErr (not frameDone) fires.

## Structure
- Shared package holds:
  - the state encoding (HUNT/LEN/DATA)
  - PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, PREAMBLE_MIN=2
  - nibble/word width constants
  - START_WR_POS default
- These are shared with the transmit controller.
- One sub-module: nibble_assembler. It owns the 2-bit phase, the 16-bit shift register and the nibble count. Its outputs are sampleSlot and wordReady. Its input is clear.
- The FSM, pointer and output registers live in the top.

## Test plan
- Reset, then nibbles 5,5,D, length 0002, words ABCD, 1234 with modemValid=1 -> writes ABCD@256 and 1234@257, frameDone with the second write, frameLen=2.
- Single 5, then D, then a valid frame -> no lock; preamble 5,5,5,D then len 0001, word BEEF -> BEEF@256.
- Length 0x0401 (>1024) -> frameErr, no memWe, wrPtr unchanged; a following valid 1-word frame writes @256.
- modemValid dropped after 3 words of an 8-word frame -> frameErr, next frame's first word lands at the same address as the aborted frame's first word.
- Preload wrPtr by sending frames until wrPtr=0x7FFF, then a 2-word frame -> writes @0x7FFF then @256.
- RST_N pulsed low mid-payload -> all outputs at reset values asynchronously; next frame writes starting @256.

Source files
------------

// File: rtl/ethernet_receiver_pkg.sv
// Shared definitions for the modem receive and transmit paths.
package ethernet_receiver_pkg;

  localparam int NIB_W         = 4;
  localparam int WORD_W        = 16;
  localparam int ADDR_W        = 15;
  localparam int NIBS_PER_WORD = WORD_W / NIB_W;

  localparam logic [NIB_W-1:0] PREAMBLE_NIB = 4'h5;
  localparam logic [NIB_W-1:0] SFD_NIB      = 4'hD;
  localparam logic [1:0]       PREAMBLE_MIN = 2'd2;

  localparam logic [ADDR_W-1:0] START_WR_POS_DEFAULT = 15'd256;
  localparam int                MAX_WORDS_DEFAULT    = 1024;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ethernet_receiver_nibble_assembler.sv
// Sample-slot generator and nibble-to-word assembler.
// A slot occurs every fourth clock (phase == 0). On each slot the incoming
// nibble is shifted in, MSB nibble first, unless clear is asserted, which
// empties the accumulator instead. wordReady flags the slot carrying the
// fourth nibble of a word; word is valid with it (the last nibble is taken
// straight from the input so the caller can act on that same edge).
module ethernet_receiver_nibble_assembler
  import ethernet_receiver_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  nibble,
  input  logic              clear,
  output logic              sampleSlot,
  output logic              wordReady,
  output logic [WORD_W-1:0] word
);

  logic [1:0]              phase;
  logic [1:0]              nib_cnt;
  logic [WORD_W-NIB_W-1:0] shift_reg;

  // Free-running phase counter; the slot is the edge where phase is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

  // Nibble accumulator, advanced or cleared only on sample slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      nib_cnt   <= 2'd0;
    end else if (sampleSlot) begin
      if (clear) begin
        shift_reg <= '0;
        nib_cnt   <= 2'd0;
      end else begin
        shift_reg <= {shift_reg[WORD_W-2*NIB_W-1:0], nibble};
        nib_cnt   <= nib_cnt + 2'd1;
      end
    end
  end

  assign sampleSlot = (phase == 2'd0);
  assign wordReady  = sampleSlot && !clear && (nib_cnt == 2'(NIBS_PER_WORD - 1));
  assign word       = {shift_reg, nibble};

endmodule

// File: rtl/ethernet_receiver.sv
// Receive framer: hunts for preamble + SFD, takes a 16-bit length word and
// then that many payload words, writing them to packet memory at a
// persistent, wrapping write pointer.
// Memory interface: memWe is a one-cycle write strobe qualifying toMemory and
// writeMemLoc in the same cycle; the memory always accepts, so there is no
// ready. frameDone/frameErr are one-cycle status pulses.
module ethernet_receiver
  import ethernet_receiver_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_WR_POS = START_WR_POS_DEFAULT,
  parameter int                MAX_WORDS    = MAX_WORDS_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NIB_W-1:0]  fromModem,
  input  logic              modemValid,
  output logic [WORD_W-1:0] toMemory,
  output logic [ADDR_W-1:0] writeMemLoc,
  output logic              memWe,
  output logic [WORD_W-1:0] frameLen,
  output logic              frameDone,
  output logic              frameErr,
  output rx_state_t         dbg_state
);

  localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(MAX_WORDS);

  rx_state_t         state, state_n;
  logic [1:0]        pre_cnt, pre_cnt_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_W-1:0] frame_start, frame_start_n;
  logic [WORD_W-1:0] remaining, remaining_n;
  logic [WORD_W-1:0] to_memory_n;
  logic [ADDR_W-1:0] write_loc_n;
  logic              mem_we_n, frame_done_n, frame_err_n;
  logic [WORD_W-1:0] frame_len_n;

  logic              sample_slot, word_ready, clear;
  logic [WORD_W-1:0] word;
  logic [ADDR_W-1:0] wr_ptr_inc;

  // Accumulator is held empty while hunting and dropped whenever carrier is lost.
  assign clear = (state == HUNT) || !modemValid;

  // Pointer wraps back to the base position rather than to zero.
  assign wr_ptr_inc = (wr_ptr == {ADDR_W{1'b1}}) ? START_WR_POS : wr_ptr + 15'd1;

  assign dbg_state = state;

  ethernet_receiver_nibble_assembler u_nibble_assembler (
    .clk        (CLK),
    .rst_n      (RST_N),
    .nibble     (fromModem),
    .clear      (clear),
    .sampleSlot (sample_slot),
    .wordReady  (word_ready),
    .word       (word)
  );

  // State, pointer and registered-output update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= HUNT;
      pre_cnt     <= 2'd0;
      wr_ptr      <= START_WR_POS;
      frame_start <= START_WR_POS;
      remaining   <= '0;
      toMemory    <= '0;
      writeMemLoc <= START_WR_POS;
      memWe       <= 1'b0;
      frameLen    <= '0;
      frameDone   <= 1'b0;
      frameErr    <= 1'b0;
    end else begin
      state       <= state_n;
      pre_cnt     <= pre_cnt_n;
      wr_ptr      <= wr_ptr_n;
      frame_start <= frame_start_n;
      remaining   <= remaining_n;
      toMemory    <= to_memory_n;
      writeMemLoc <= write_loc_n;
      memWe       <= mem_we_n;
      frameLen    <= frame_len_n;
      frameDone   <= frame_done_n;
      frameErr    <= frame_err_n;
    end
  end

  // Next-state and output decode; everything only moves on a sample slot.
  always_comb begin
    state_n       = state;
    pre_cnt_n     = pre_cnt;
    wr_ptr_n      = wr_ptr;
    frame_start_n = frame_start;
    remaining_n   = remaining;
    to_memory_n   = toMemory;
    write_loc_n   = writeMemLoc;
    mem_we_n      = 1'b0;
    frame_len_n   = frameLen;
    frame_done_n  = 1'b0;
    frame_err_n   = 1'b0;
    if (sample_slot) begin
      case (state)
        HUNT: begin
          if (!modemValid) begin
            pre_cnt_n = 2'd0;
          end else if (fromModem == PREAMBLE_NIB) begin
            if (pre_cnt < PREAMBLE_MIN) pre_cnt_n = pre_cnt + 2'd1;
          end else if (fromModem == SFD_NIB && pre_cnt == PREAMBLE_MIN) begin
            state_n       = LEN;
            frame_start_n = wr_ptr;
            pre_cnt_n     = 2'd0;
          end else begin
            pre_cnt_n = 2'd0;
          end
        end
        LEN: begin
          pre_cnt_n = 2'd0;
          if (!modemValid) begin
            frame_err_n = 1'b1;
            wr_ptr_n    = frame_start;
            state_n     = HUNT;
          end else if (word_ready) begin
            frame_len_n = word;
            if (word == '0) begin
              frame_done_n = 1'b1;
              state_n      = HUNT;
            end else if (word > MAX_LEN) begin
              frame_err_n = 1'b1;
              state_n     = HUNT;
            end else begin
              remaining_n = word;
              state_n     = DATA;
            end
          end
        end
        DATA: begin
          pre_cnt_n = 2'd0;
          if (!modemValid) begin
            // Abort wins over completion, even on the last word's final nibble.
            frame_err_n = 1'b1;
            wr_ptr_n    = frame_start;
            state_n     = HUNT;
          end else if (word_ready) begin
            to_memory_n = word;
            write_loc_n = wr_ptr;
            mem_we_n    = 1'b1;
            wr_ptr_n    = wr_ptr_inc;
            remaining_n = remaining - 16'd1;
            if (remaining == 16'd1) begin
              frame_done_n = 1'b1;
              state_n      = HUNT;
            end
          end
        end
        default: begin
          state_n   = HUNT;
          pre_cnt_n = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_receiver.sv
// Bench for ethernet_receiver: frame-level reference model feeding an
// expected-event queue, and a monitor that compares every DUT output event.
// A second instance with a base near the top of the address space exercises
// pointer wrap within a short run.
module tb_ethernet_receiver;
  import ethernet_receiver_pkg::*;

  localparam logic [14:0] BASE  = 15'd256;
  localparam logic [14:0] BASE2 = 15'h7FFC;
  localparam int          MAXW  = 1024;
  localparam int          EW    = 50;

  // clock / reset
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [3:0]  fromModem = 4'h0;
  logic        modemValid = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] toMemory, frameLen;
  logic [14:0] writeMemLoc;
  logic        memWe, frameDone, frameErr;
  rx_state_t   dbg_state;

  logic [15:0] toMemory2, frameLen2;
  logic [14:0] writeMemLoc2;
  logic        memWe2, frameDone2, frameErr2;
  rx_state_t   dbg_state2;

  ethernet_receiver dut (
    .CLK(CLK), .RST_N(RST_N), .fromModem(fromModem), .modemValid(modemValid),
    .toMemory(toMemory), .writeMemLoc(writeMemLoc), .memWe(memWe),
    .frameLen(frameLen), .frameDone(frameDone), .frameErr(frameErr),
    .dbg_state(dbg_state)
  );

  ethernet_receiver #(.START_WR_POS(BASE2)) dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .fromModem(fromModem), .modemValid(modemValid),
    .toMemory(toMemory2), .writeMemLoc(writeMemLoc2), .memWe(memWe2),
    .frameLen(frameLen2), .frameDone(frameDone2), .frameErr(frameErr2),
    .dbg_state(dbg_state2)
  );

  // scoreboard state
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [30:0]   exp2_q[$];
  logic [14:0]   m_ptr = BASE;
  logic [14:0]   m_ptr2 = BASE2;
  logic [15:0]   m_len = 16'h0;
  bit            glitch_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] nxt(input logic [14:0] p, input logic [14:0] b);
    return (p == 15'h7FFF) ? b : p + 15'd1;
  endfunction

  // event = {we, done, err, frameLen, addr, data}; addr/data zero unless we
  function automatic logic [EW-1:0] ev(input logic we, input logic done, input logic err,
                                       input logic [15:0] len, input logic [14:0] a,
                                       input logic [15:0] d);
    return {we, done, err, len, a, d};
  endfunction

  // monitor: main instance, every strobe/pulse is one expected event
  always @(negedge CLK) begin
    logic [EW-1:0] act;
    if (RST_N && (memWe || frameDone || frameErr)) begin
      act = ev(memWe, frameDone, frameErr, frameLen,
               memWe ? writeMemLoc : 15'd0, memWe ? toMemory : 16'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %0h expected none", act);
      end else begin
        check("event", act, exp_q.pop_front());
      end
    end
  end

  // monitor: wrap instance, writes only
  always @(negedge CLK) begin
    if (RST_N && memWe2) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wrap_write: got %0h@%0h expected none", toMemory2, writeMemLoc2);
      end else begin
        check("wrap_write", {writeMemLoc2, toMemory2}, exp2_q.pop_front());
      end
    end
  end

  // driver: one nibble occupies four clocks, first edge is the sample slot
  task automatic send_nib(input logic [3:0] n, input logic v);
    fromModem  = n;
    modemValid = v;
    @(posedge CLK); #1;
    for (int c = 0; c < 3; c++) begin
      if (glitch_en && v) begin
        fromModem  = 4'($urandom_range(0, 15));
        modemValid = 1'($urandom_range(0, 1));
      end
      @(posedge CLK); #1;
    end
  endtask

  // driver + reference model for one frame.
  // abort_at / cut_at: nibble index after the SFD where carrier drops / the
  // stream simply stops (-1 = never).
  task automatic send_frame(input int npre, input logic [15:0] len, input int abort_at,
                            input int cut_at, input logic [15:0] w0, input logic [15:0] w1);
    logic [14:0] s1, s2;
    logic [15:0] w;
    bit          accept;
    int          idx;
    send_nib(4'($urandom_range(0, 15)), 1'b0);
    repeat (npre) send_nib(PREAMBLE_NIB, 1'b1);
    send_nib(SFD_NIB, 1'b1);
    s1 = m_ptr;
    s2 = m_ptr2;
    accept = (len != 16'd0) && (int'(len) <= MAXW);
    for (int i = 0; i < 4; i++) begin
      if (i == cut_at) return;
      if (i == abort_at) begin
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, m_len, 15'd0, 16'd0));
        m_ptr = s1;
        m_ptr2 = s2;
        send_nib(4'($urandom_range(0, 15)), 1'b0);
        return;
      end
      if (i == 3) begin
        m_len = len;
        if (len == 16'd0) exp_q.push_back(ev(1'b0, 1'b1, 1'b0, len, 15'd0, 16'd0));
        else if (!accept) exp_q.push_back(ev(1'b0, 1'b0, 1'b1, len, 15'd0, 16'd0));
      end
      send_nib(len[15-4*i -: 4], 1'b1);
    end
    if (!accept) return;
    for (int wi = 0; wi < int'(len); wi++) begin
      w = (wi == 0) ? w0 : (wi == 1) ? w1 : 16'($urandom);
      for (int n = 0; n < 4; n++) begin
        idx = 4 + 4 * wi + n;
        if (idx == cut_at) return;
        if (idx == abort_at) begin
          exp_q.push_back(ev(1'b0, 1'b0, 1'b1, m_len, 15'd0, 16'd0));
          m_ptr = s1;
          m_ptr2 = s2;
          send_nib(4'($urandom_range(0, 15)), 1'b0);
          return;
        end
        if (n == 3) begin
          exp_q.push_back(ev(1'b1, wi == int'(len) - 1, 1'b0, m_len, m_ptr, w));
          exp2_q.push_back({m_ptr2, w});
          m_ptr = nxt(m_ptr, BASE);
          m_ptr2 = nxt(m_ptr2, BASE2);
        end
        send_nib(w[15-4*n -: 4], 1'b1);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_toMemory"}, toMemory, 16'h0);
    check({tag, "_writeMemLoc"}, writeMemLoc, BASE);
    check({tag, "_memWe"}, memWe, 1'b0);
    check({tag, "_frameLen"}, frameLen, 16'h0);
    check({tag, "_frameDone"}, frameDone, 1'b0);
    check({tag, "_frameErr"}, frameErr, 1'b0);
    check({tag, "_state"}, dbg_state, HUNT);
  endtask

  initial begin
    int          npre, abort_at;
    logic [15:0] len;
    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_reset_values("reset");
    @(negedge CLK) RST_N = 1'b1;

    // basic two-word frame
    send_frame(2, 16'h0002, -1, -1, 16'hABCD, 16'h1234);
    check("len_after_basic", frameLen, 16'h0002);

    // lone 5 then D must not lock; longer preamble does
    send_nib(PREAMBLE_NIB, 1'b1);
    send_nib(SFD_NIB, 1'b1);
    check("no_lock_state", dbg_state, HUNT);
    send_frame(3, 16'h0001, -1, -1, 16'hBEEF, 16'h0);

    // over-length rejected, zero length completes empty, max length accepted
    send_frame(2, 16'h0401, -1, -1, 16'h0, 16'h0);
    check("len_after_reject", frameLen, 16'h0401);
    send_frame(2, 16'h0001, -1, -1, 16'h5A5A, 16'h0);
    send_frame(2, 16'h0000, -1, -1, 16'h0, 16'h0);
    send_frame(2, 16'(MAXW), -1, -1, 16'h1111, 16'h2222);

    // carrier loss: after 3 of 8 words, in the length field, and on the last nibble
    send_frame(2, 16'h0008, 4 + 12, -1, 16'hC0DE, 16'hF00D);
    send_frame(2, 16'h0002, -1, -1, 16'h7777, 16'h8888);
    send_frame(2, 16'h0005, 2, -1, 16'h0, 16'h0);
    send_frame(2, 16'h0002, 4 + 4 + 3, -1, 16'h3333, 16'h4444);
    send_frame(2, 16'h0003, -1, -1, 16'h9999, 16'hAAAA);

    // randomized traffic with off-slot glitches on the inputs
    glitch_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      npre = $urandom_range(2, 4);
      case ($urandom_range(0, 9))
        0:       len = 16'h0;
        1:       len = 16'($urandom_range(MAXW + 1, 65535));
        default: len = 16'($urandom_range(1, 12));
      endcase
      abort_at = -1;
      if ($urandom_range(0, 3) == 0)
        abort_at = $urandom_range(0, 3 + ((len != 0 && int'(len) <= MAXW) ? 4 * int'(len) : 0));
      send_frame(npre, len, abort_at, -1, 16'($urandom), 16'($urandom));
    end
    glitch_en = 1'b0;

    // reset asserted mid-payload
    send_frame(2, 16'h0006, -1, 4 + 8 + 2, 16'hDEAD, 16'hCAFE);
    #2 RST_N = 1'b0;
    #1 check_reset_values("midreset");
    check("midreset_pending", exp_q.size(), 0);
    m_ptr = BASE;
    m_ptr2 = BASE2;
    m_len = 16'h0;
    @(negedge CLK) RST_N = 1'b1;
    send_frame(2, 16'h0002, -1, -1, 16'h0BAD, 16'hF00D);

    repeat (8) @(posedge CLK);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("exp2_q_drained", exp2_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
